// File: rtl/icache_fetch_responder_pkg.sv
// icache_fetch_responder_pkg: shared widths and FSM encoding for the direct-mapped instruction cache
package icache_fetch_responder_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int INDEX_BITS_DEF = 8;
    typedef enum logic {IDLE, MISS} state_t;
    function automatic int tag_w(input int aw, input int ib);
        return aw - ib - 2;
    endfunction
endpackage

// File: rtl/icache_fetch_responder_if.sv
// icache_fetch_responder_if: fetch-side and memory-side signals of the instruction cache
interface icache_fetch_responder_if
    import icache_fetch_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_pc;
    logic              flush;
    logic              Instr_valid;
    logic [31:0]       Instr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_done;
    logic [31:0]       mem_data;
    modport master (
        output fetch_en, fetch_pc, flush, mem_done, mem_data,
        input  Instr_valid, Instr, mem_req, mem_addr
    );
    modport slave (
        input  fetch_en, fetch_pc, flush, mem_done, mem_data,
        output Instr_valid, Instr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage, combinational read port, single write port
module icache_line_array
    import icache_fetch_responder_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_W = tag_w(ADDR_W_DEF, INDEX_BITS_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr [LINES];
    logic [31:0]      data_arr [LINES];
    always_ff @(posedge clk or posedge rst)
        if (rst) valid <= '0;
        else if (we) valid[wr_idx] <= 1'b1;
    // tag/data need no reset: they are only trusted behind a valid bit
    always_ff @(posedge clk)
        if (we) begin
            tag_arr[wr_idx]  <= wr_tag;
            data_arr[wr_idx] <= wr_data;
        end
    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx];
endmodule

// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: direct-mapped I-cache answering fetches, refilling misses from memory
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    icache_fetch_responder_if.slave bus
);
    localparam int TAG_W = tag_w(ADDR_W, INDEX_BITS);
    state_t            state, state_n;
    logic              abort, abort_n, valid_n, req_n, fill, rd_valid, hit;
    logic [31:0]       instr_n, rd_data;
    logic [ADDR_W-1:0] addr_n;
    logic [TAG_W-1:0]  rd_tag;
    icache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_lines (
        .clk(clk),
        .rst(rst),
        .rd_idx(bus.fetch_pc[INDEX_BITS+1:2]),
        .rd_valid(rd_valid),
        .rd_tag(rd_tag),
        .rd_data(rd_data),
        .we(fill && rdy),
        .wr_idx(bus.mem_addr[INDEX_BITS+1:2]),
        .wr_tag(bus.mem_addr[ADDR_W-1:INDEX_BITS+2]),
        .wr_data(bus.mem_data)
    );
    assign hit = rd_valid && rd_tag == bus.fetch_pc[ADDR_W-1:INDEX_BITS+2];
    // mem_addr doubles as the latched miss pc, so the refill index/tag come from it
    always_comb begin
        state_n = state;
        abort_n = abort;
        valid_n = 1'b0;
        instr_n = bus.Instr;
        req_n   = bus.mem_req;
        addr_n  = bus.mem_addr;
        fill    = 1'b0;
        if (state == IDLE) begin
            if (bus.fetch_en && !bus.flush) begin
                valid_n = hit;
                instr_n = hit ? rd_data : bus.Instr;
                req_n   = !hit;
                addr_n  = hit ? bus.mem_addr : {bus.fetch_pc[ADDR_W-1:2], 2'b00};
                abort_n = hit ? abort : 1'b0;
                state_n = hit ? IDLE : MISS;
            end
        end else begin
            abort_n = abort | bus.flush;
            if (bus.mem_done) begin
                fill    = 1'b1;
                req_n   = 1'b0;
                state_n = IDLE;
                valid_n = !abort_n;
                instr_n = abort_n ? bus.Instr : bus.mem_data;
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            abort           <= 1'b0;
            bus.Instr_valid <= 1'b0;
            bus.Instr       <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
        end else if (rdy) begin
            state           <= state_n;
            abort           <= abort_n;
            bus.Instr_valid <= valid_n;
            bus.Instr       <= instr_n;
            bus.mem_req     <= req_n;
            bus.mem_addr    <= addr_n;
        end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// tb_icache_fetch_responder: directed and random fetch traffic checked against a transaction-level cache model
module tb_icache_fetch_responder;
    import icache_fetch_responder_pkg::*;
    logic clk = 0, rst = 1, rdy = 1;
    icache_fetch_responder_if bus();
    icache_fetch_responder dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
    always #5 clk = ~clk;
    int n_cmp = 0, n_fail = 0;
    bit rnd = 0, auto_mem = 0;
    int wait_cnt = 0;
    typedef struct { logic [31:0] addr; bit cancelled; } miss_t;
    miss_t pend[$];
    bit m_v[256];
    logic [21:0] m_tag[256];
    logic [31:0] m_data[256];
    logic exp_valid = 0, exp_req = 0;
    logic [31:0] exp_instr = 0, exp_addr = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // model: cache contents as arrays, outstanding miss as a queue entry
    always @(posedge clk or posedge rst) begin : model
        int i;
        if (rst) begin
            foreach (m_v[k]) m_v[k] = 0;
            pend.delete();
            exp_valid = 0; exp_req = 0; exp_instr = 0; exp_addr = 0;
        end else if (rdy) begin
            exp_valid = 0;
            if (pend.size() == 0) begin
                if (bus.fetch_en && !bus.flush) begin
                    i = int'(bus.fetch_pc[9:2]);
                    if (m_v[i] && m_tag[i] == bus.fetch_pc[31:10]) begin
                        exp_valid = 1;
                        exp_instr = m_data[i];
                    end else begin
                        pend.push_back('{{bus.fetch_pc[31:2], 2'b00}, 1'b0});
                        exp_req  = 1;
                        exp_addr = {bus.fetch_pc[31:2], 2'b00};
                    end
                end
            end else begin
                if (bus.flush) pend[0].cancelled = 1;
                if (bus.mem_done) begin
                    i = int'(pend[0].addr[9:2]);
                    m_v[i] = 1;
                    m_tag[i] = pend[0].addr[31:10];
                    m_data[i] = bus.mem_data;
                    exp_req = 0;
                    if (!pend[0].cancelled) begin
                        exp_valid = 1;
                        exp_instr = bus.mem_data;
                    end
                    void'(pend.pop_front());
                end
            end
        end
    end
    always @(negedge clk)
        if (!rst) begin
            chk("instr_valid", bus.Instr_valid, exp_valid);
            chk("instr", bus.Instr, exp_instr);
            chk("mem_req", bus.mem_req, exp_req);
            chk("mem_addr", bus.mem_addr, exp_addr);
        end
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    task automatic step();
        logic [31:0] pc;
        @(posedge clk);
        #1;
        if (rnd) begin
            pc = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if (pc[11]) pc = pc | 32'h8000_0000;
            bus.fetch_en = $urandom_range(0, 1);
            bus.fetch_pc = pc;
            bus.flush = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) != 0);
        end
        if (auto_mem) begin
            bus.mem_done = 0;
            if (bus.mem_req && rdy) begin
                if (wait_cnt == 0) begin
                    bus.mem_done = 1;
                    bus.mem_data = memword(bus.mem_addr);
                    wait_cnt = $urandom_range(0, 3);
                end else wait_cnt--;
            end
        end
    endtask
    task automatic fetch(input logic [31:0] pc);
        bus.fetch_en = 1;
        bus.fetch_pc = pc;
        step();
        bus.fetch_en = 0;
    endtask
    task automatic fill(input logic [31:0] d);
        bus.mem_done = 1;
        bus.mem_data = d;
        step();
        bus.mem_done = 0;
    endtask
    initial begin
        bus.fetch_en = 0; bus.fetch_pc = 0; bus.flush = 0; bus.mem_done = 0; bus.mem_data = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", bus.Instr_valid, 0);
        chk("rst_instr", bus.Instr, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        fetch(32'h0);
        chk("miss0_req", bus.mem_req, 1);
        chk("miss0_addr", bus.mem_addr, 32'h0);
        fill(32'h0000_0093);
        chk("fill0_valid", bus.Instr_valid, 1);
        chk("fill0_instr", bus.Instr, 32'h0000_0093);
        chk("fill0_req", bus.mem_req, 0);
        step();
        chk("pulse_once", bus.Instr_valid, 0);
        fetch(32'h0);
        chk("hit0_valid", bus.Instr_valid, 1);
        chk("hit0_instr", bus.Instr, 32'h0000_0093);
        chk("hit0_req", bus.mem_req, 0);
        fetch(32'h4);
        chk("miss4_addr", bus.mem_addr, 32'h4);
        fill(32'h1111_1111);
        fetch(32'h404);
        chk("alias_req", bus.mem_req, 1);
        chk("alias_addr", bus.mem_addr, 32'h404);
        fill(32'h2222_2222);
        chk("alias_instr", bus.Instr, 32'h2222_2222);
        fetch(32'h4);
        chk("evict_req", bus.mem_req, 1);
        fill(32'h1111_1111);
        chk("evict_instr", bus.Instr, 32'h1111_1111);
        fetch(32'h100);
        step();
        bus.flush = 1;
        step();
        bus.flush = 0;
        step();
        fill(32'hDEAD_BEEF);
        chk("flush_mid_valid", bus.Instr_valid, 0);
        chk("flush_mid_req", bus.mem_req, 0);
        fetch(32'h100);
        chk("flush_mid_hit", bus.Instr_valid, 1);
        chk("flush_mid_data", bus.Instr, 32'hDEAD_BEEF);
        fetch(32'h200);
        bus.flush = 1;
        fill(32'h1234_5678);
        bus.flush = 0;
        chk("flush_coin_valid", bus.Instr_valid, 0);
        fetch(32'h200);
        chk("flush_coin_hit", bus.Instr, 32'h1234_5678);
        bus.flush = 1;
        fetch(32'h300);
        bus.flush = 0;
        chk("flush_idle_valid", bus.Instr_valid, 0);
        chk("flush_idle_req", bus.mem_req, 0);
        fetch(32'h0);
        rdy = 0;
        repeat (3) begin
            step();
            chk("hold_valid", bus.Instr_valid, 1);
            chk("hold_instr", bus.Instr, 32'h0000_0093);
        end
        rdy = 1;
        step();
        chk("hold_release", bus.Instr_valid, 0);
        fetch(32'h500);
        chk("rst_miss_req", bus.mem_req, 1);
        #2 rst = 1;
        #1 chk("async_rst_req", bus.mem_req, 0);
        @(posedge clk);
        #1 rst = 0;
        fetch(32'h0);
        chk("invalid_after_rst", bus.mem_req, 1);
        fill(32'h0000_0093);
        auto_mem = 1;
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        rdy = 1;
        bus.fetch_en = 0;
        bus.flush = 0;
        for (int k = 0; k < 50 && bus.mem_req; k++) step();
        chk("drain_req", bus.mem_req, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
